// File: rtl/seq_loader_ctrl.sv
// seq_loader_ctrl
// ---------------
// Sequence generator and sequence store for the Simon game. A load request
// seeds an 8-bit LFSR from SEED mixed with a free-running entropy byte, then
// writes DEPTH two-bit colours, one per tick. The game FSM reads the store
// through a combinational read port that stays blocked until the whole
// sequence has been written.
//
// Read-port handshake: start_play is the "valid" level for the whole store.
// rd_stall = ~start_play. While rd_stall is high, rd_data is forced to 0 and
// the consumer must not use it. While rd_stall is low, rd_data = mem[rd_addr]
// in the same cycle for rd_addr < DEPTH, and 0 for any higher address. The
// load request has no ready: it is accepted only in IDLE or READY and
// dropped in SEED and FILL.
//
// Ports:
//   clk_tick    game tick clock; all state changes on its rising edge
//   reset_n     asynchronous active-low reset
//   load_req    request a new sequence
//   entropy     free-running byte mixed into the LFSR seed
//   rd_addr     read address from the game FSM
//   rd_data     colour at rd_addr (combinational, gated)
//   rd_stall    read port blocked
//   start_play  a complete sequence is held
//   busy        seeding or filling
//   fill_cnt    entries written so far
//   dbg_state   current FSM state (0 IDLE, 1 SEED, 2 FILL, 3 READY)

module seq_loader_ctrl #(
    parameter int          DEPTH     = 10,
    parameter logic [7:0]  SEED      = 8'hA5,
    parameter bit          NO_REPEAT = 1'b1
) (
    input  logic       clk_tick,
    input  logic       reset_n,
    input  logic       load_req,
    input  logic [7:0] entropy,
    input  logic [3:0] rd_addr,
    output logic [1:0] rd_data,
    output logic       rd_stall,
    output logic       start_play,
    output logic       busy,
    output logic [3:0] fill_cnt,
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEED  = 2'd1,
        ST_FILL  = 2'd2,
        ST_READY = 2'd3
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(DEPTH - 1);
    // One bit wider than rd_addr so DEPTH = 16 still compares correctly.
    localparam logic [4:0] DEPTH_W  = 5'(DEPTH);

    state_t     state;
    state_t     state_next;
    logic [7:0] lfsr;
    logic [1:0] prev;
    logic [3:0] wr_idx;
    logic [1:0] mem [DEPTH];

    logic [7:0] seed_mix;
    logic [7:0] seed_val;
    logic [7:0] lfsr_adv;
    logic [1:0] colour;

    // Datapath helpers
    always_comb begin
        seed_mix = SEED ^ entropy;
        // An all-zero LFSR would lock up, so fall back to the base seed.
        seed_val = (seed_mix == 8'h00) ? SEED : seed_mix;
        lfsr_adv = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        colour   = lfsr[1:0];
        if (NO_REPEAT && (wr_idx != 4'd0) && (lfsr[1:0] == prev)) begin
            colour = lfsr[1:0] + 2'd1;
        end
    end

    // FSM next state and outputs
    always_comb begin
        state_next = state;
        start_play = 1'b0;
        busy       = 1'b0;
        fill_cnt   = 4'd0;
        case (state)
            ST_IDLE: begin
                if (load_req) begin
                    state_next = ST_SEED;
                end
            end
            ST_SEED: begin
                busy       = 1'b1;
                state_next = ST_FILL;
            end
            ST_FILL: begin
                busy     = 1'b1;
                fill_cnt = wr_idx;
                if (wr_idx == LAST_IDX) begin
                    state_next = ST_READY;
                end
            end
            ST_READY: begin
                start_play = 1'b1;
                fill_cnt   = DEPTH_W[3:0];
                if (load_req) begin
                    state_next = ST_SEED;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk_tick or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            lfsr   <= SEED;
            prev   <= 2'd0;
            wr_idx <= 4'd0;
        end else begin
            state <= state_next;
            case (state)
                ST_SEED: begin
                    lfsr   <= seed_val;
                    wr_idx <= 4'd0;
                end
                ST_FILL: begin
                    prev   <= colour;
                    lfsr   <= lfsr_adv;
                    wr_idx <= wr_idx + 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

    // Sequence store: not reset; the READY gating on the read port hides
    // whatever a previous or interrupted fill left behind.
    always_ff @(posedge clk_tick) begin
        if (state == ST_FILL) begin
            mem[wr_idx] <= colour;
        end
    end

    // Read port
    always_comb begin
        rd_data = 2'b00;
        if ((state == ST_READY) && ({1'b0, rd_addr} < DEPTH_W)) begin
            rd_data = mem[rd_addr];
        end
    end

    assign rd_stall  = ~start_play;
    assign dbg_state = state;

endmodule

// File: tb/tb_seq_loader_ctrl.sv
module tb_seq_loader_ctrl;

    logic       clk_tick;
    logic       reset_n;
    logic       load_req;
    logic [7:0] entropy;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic       rd_stall;
    logic       start_play;
    logic       busy;
    logic [3:0] fill_cnt;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] addr;
        logic [1:0] exp_data;
        logic       exp_stall;
    } rd_vec_t;

    rd_vec_t    tbl [16];
    logic [1:0] exp_seq [10];
    // Hand-computed sequences: seed 8'hA5 and seed 8'hFF (entropy 8'h5A).
    logic [1:0] seq_a [10] = '{2'd1, 2'd2, 2'd1, 2'd2, 2'd0, 2'd1, 2'd3, 2'd0, 2'd2, 2'd1};
    logic [1:0] seq_b [10] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2, 2'd1, 2'd3, 2'd0};

    seq_loader_ctrl #(
        .DEPTH(10),
        .SEED(8'hA5),
        .NO_REPEAT(1'b1)
    ) dut (
        .clk_tick  (clk_tick),
        .reset_n   (reset_n),
        .load_req  (load_req),
        .entropy   (entropy),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_stall  (rd_stall),
        .start_play(start_play),
        .busy      (busy),
        .fill_cnt  (fill_cnt),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk_tick = 1'b0;
    always #5 clk_tick = ~clk_tick;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Read every address in READY against the expected sequence.
    task automatic check_ready_table();
        for (int i = 0; i < 16; i++) begin
            tbl[i].addr      = 4'(i);
            tbl[i].exp_data  = (i < 10) ? exp_seq[i] : 2'b00;
            tbl[i].exp_stall = 1'b0;
        end
        for (int i = 0; i < 16; i++) begin
            rd_addr = tbl[i].addr;
            #1;
            check($sformatf("rd_data[%0d]", i), 32'(rd_data), 32'(tbl[i].exp_data));
            check($sformatf("rd_stall[%0d]", i), 32'(rd_stall), 32'(tbl[i].exp_stall));
        end
        for (int i = 1; i < 10; i++) begin
            rd_addr = 4'(i - 1);
            #1;
            begin
                logic [1:0] a;
                a = rd_data;
                rd_addr = 4'(i);
                #1;
                check($sformatf("no_repeat[%0d]", i), 32'(rd_data != a), 32'd1);
            end
        end
        rd_addr = 4'd3;
    endtask

    // Issue one load_req pulse and follow the fill to READY.
    // pulse_at > 0 re-asserts load_req for one edge mid-fill.
    task automatic run_load(input logic [7:0] ent, input int pulse_at);
        int n;
        @(negedge clk_tick);
        entropy  = ent;
        load_req = 1'b1;
        rd_addr  = 4'd3;
        @(posedge clk_tick);
        @(negedge clk_tick);
        load_req = 1'b0;
        check("seed_busy", 32'(busy), 32'd1);
        check("seed_start", 32'(start_play), 32'd0);
        check("seed_fill", 32'(fill_cnt), 32'd0);
        check("seed_state", 32'(dbg_state), 32'd1);
        n = 0;
        while (!start_play && n < 40) begin
            @(posedge clk_tick);
            n++;
            @(negedge clk_tick);
            load_req = (n == pulse_at);
            if (!start_play) begin
                check("fill_cnt", 32'(fill_cnt), 32'(n - 1));
                check("fill_rd_data", 32'(rd_data), 32'd0);
                check("fill_stall", 32'(rd_stall), 32'd1);
                check("fill_busy", 32'(busy), 32'd1);
            end
        end
        load_req = 1'b0;
        check("start_latency", 32'(n + 1), 32'd12);
        check("ready_busy", 32'(busy), 32'd0);
        check("ready_fill", 32'(fill_cnt), 32'd10);
        check("ready_state", 32'(dbg_state), 32'd3);
    endtask

    initial begin
        int n;
        reset_n  = 1'b0;
        load_req = 1'b0;
        entropy  = 8'h00;
        rd_addr  = 4'd0;

        // Reset values
        repeat (2) @(negedge clk_tick);
        check("rst_start", 32'(start_play), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fill", 32'(fill_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
        for (int i = 0; i < 16; i++) begin
            rd_addr = 4'(i);
            #1;
            check("rst_rd_data", 32'(rd_data), 32'd0);
            check("rst_stall", 32'(rd_stall), 32'd1);
        end
        @(negedge clk_tick);
        reset_n = 1'b1;
        @(negedge clk_tick);
        check("idle_state", 32'(dbg_state), 32'd0);

        // Entropy 0: seed A5
        for (int i = 0; i < 10; i++) exp_seq[i] = seq_a[i];
        run_load(8'h00, 0);
        check_ready_table();

        // Entropy A5: XOR is zero, falls back to A5 -> same sequence
        run_load(8'hA5, 0);
        check_ready_table();

        // Entropy 5A: seed FF, different sequence; load_req during FILL ignored
        for (int i = 0; i < 10; i++) exp_seq[i] = seq_b[i];
        run_load(8'h5A, 4);
        check_ready_table();

        // Reset at the 5th FILL write
        @(negedge clk_tick);
        entropy  = 8'h00;
        load_req = 1'b1;
        rd_addr  = 4'd0;
        @(posedge clk_tick);
        @(negedge clk_tick);
        load_req = 1'b0;
        repeat (6) @(negedge clk_tick);
        check("mid_fill_cnt", 32'(fill_cnt), 32'd5);
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(dbg_state), 32'd0);
        check("mid_rst_fill", 32'(fill_cnt), 32'd0);
        check("mid_rst_start", 32'(start_play), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rd", 32'(rd_data), 32'd0);
        @(negedge clk_tick);
        reset_n = 1'b1;
        @(negedge clk_tick);
        check("post_rst_stall", 32'(rd_stall), 32'd1);
        check("post_rst_rd", 32'(rd_data), 32'd0);
        for (int i = 0; i < 10; i++) exp_seq[i] = seq_a[i];
        run_load(8'h00, 0);
        check_ready_table();

        // load_req held high: start_play high for one cycle, then reload
        @(negedge clk_tick);
        load_req = 1'b1;
        n = 0;
        @(posedge clk_tick);
        @(negedge clk_tick);
        check("hold_drop", 32'(start_play), 32'd0);
        while (!start_play && n < 40) begin
            @(posedge clk_tick);
            n++;
            @(negedge clk_tick);
        end
        check("hold_latency", 32'(n + 1), 32'd12);
        @(posedge clk_tick);
        @(negedge clk_tick);
        check("hold_pulse_end", 32'(start_play), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
        load_req = 1'b0;
        n = 0;
        while (!start_play && n < 40) begin
            @(posedge clk_tick);
            n++;
            @(negedge clk_tick);
        end
        check("hold_final_ready", 32'(start_play), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
